gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor.sv | 138 +++++++++++++
 tb/tb_gshare_predictor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: a PHT of saturating counters indexed by PC XOR speculative
// global history, with an in-order queue of in-flight predictions for training and repair.
`timescale 1ns/1ps

module gshare_predictor #(
  parameter int unsigned GHR_BITS   = 8,
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PC_LSB     = 2
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         predict_valid,
  input  logic [31:0]                  predict_pc,
  output logic                         predict_ready,
  output logic                         predict_taken,
  input  logic                         resolve_valid,
  input  logic                         resolve_taken,
  output logic                         resolve_mispredict,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   inflight_count
);

  localparam int unsigned PHT_N = 1 << INDEX_BITS;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [CTR_BITS-1:0] ctr_t;

  localparam ctr_t CTR_MAX  = '1;
  localparam ctr_t CTR_INIT = ctr_t'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [31:0] PC_IDX_MASK = 32'(((64'd1 << INDEX_BITS) - 64'd1) << PC_LSB);

  typedef struct packed {
    logic [INDEX_BITS-1:0] index;
    logic                  pred;
  } entry_t;

  ctr_t                  pht_q [PHT_N];
  ctr_t                  pht_d [PHT_N];
  entry_t                q_q   [DEPTH];
  entry_t                q_d   [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [GHR_BITS-1:0]   spec_ghr_q, spec_ghr_d;
  logic [GHR_BITS-1:0]   arch_ghr_q, arch_ghr_d;

  logic [INDEX_BITS-1:0] index_c;
  logic                  accept_c;
  logic                  res_acc_c;
  logic                  squash_c;
  entry_t                head_entry_c;
  ctr_t                  head_ctr_c;
  logic                  unused_pc_bits;

  // PC bits outside the index field do not participate in prediction.
  assign unused_pc_bits = ^(predict_pc & ~PC_IDX_MASK);

  // Prediction lookup and handshake qualifiers, all from current state.
  always_comb begin
    index_c            = predict_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(spec_ghr_q);
    predict_taken      = pht_q[index_c][CTR_BITS-1];
    predict_ready      = (count_q != CNT_W'(DEPTH));
    inflight_count     = count_q;
    accept_c           = predict_valid && predict_ready;
    res_acc_c          = resolve_valid && (count_q != '0);
    head_entry_c       = q_q[head_q];
    head_ctr_c         = pht_q[head_entry_c.index];
    resolve_mispredict = res_acc_c && (resolve_taken != head_entry_c.pred);
    squash_c           = flush || resolve_mispredict;
  end

  // Next-state: PHT training, history update, queue push/pop and repair.
  always_comb begin
    pht_d      = pht_q;
    q_d        = q_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    spec_ghr_d = spec_ghr_q;
    arch_ghr_d = arch_ghr_q;

    if (res_acc_c) begin
      if (resolve_taken) begin
        if (head_ctr_c != CTR_MAX) pht_d[head_entry_c.index] = head_ctr_c + ctr_t'(1);
      end else begin
        if (head_ctr_c != '0) pht_d[head_entry_c.index] = head_ctr_c - ctr_t'(1);
      end
      arch_ghr_d = {arch_ghr_q[GHR_BITS-2:0], resolve_taken};
    end

    if (squash_c) begin
      // Squash drops every in-flight entry and restores history from the retired stream.
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      spec_ghr_d = arch_ghr_d;
    end else begin
      if (accept_c) begin
        q_d[tail_q] = '{index: index_c, pred: predict_taken};
        tail_d      = tail_q + PTR_W'(1);
        spec_ghr_d  = {spec_ghr_q[GHR_BITS-2:0], predict_taken};
      end
      if (res_acc_c) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({accept_c, res_acc_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < PHT_N; i++) pht_q[i] <= CTR_INIT;
      for (int unsigned i = 0; i < DEPTH; i++) q_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      spec_ghr_q <= '0;
      arch_ghr_q <= '0;
    end else begin
      pht_q      <= pht_d;
      q_q        <= q_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      spec_ghr_q <= spec_ghr_d;
      arch_ghr_q <= arch_ghr_d;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: driver pushes reference-model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps

module tb_gshare_predictor;

  localparam int GHR_BITS   = 8;
  localparam int INDEX_BITS = 8;
  localparam int CTR_BITS   = 2;
  localparam int DEPTH      = 4;
  localparam int PC_LSB     = 2;
  localparam int PHT_N      = 2 ** INDEX_BITS;
  localparam int GHR_N      = 2 ** GHR_BITS;
  localparam int CTR_MAXV   = 2 ** CTR_BITS - 1;
  localparam int CTR_INITV  = 2 ** (CTR_BITS - 1) - 1;
  localparam int TAKEN_MIN  = 2 ** (CTR_BITS - 1);

  logic        CLK = 1'b0;
  logic        nRST;
  logic        predict_valid;
  logic [31:0] predict_pc;
  logic        predict_ready;
  logic        predict_taken;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        resolve_mispredict;
  logic        flush;
  logic [$clog2(DEPTH+1)-1:0] inflight_count;

  gshare_predictor #(
    .GHR_BITS(GHR_BITS), .INDEX_BITS(INDEX_BITS), .CTR_BITS(CTR_BITS),
    .DEPTH(DEPTH), .PC_LSB(PC_LSB)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .predict_valid(predict_valid), .predict_pc(predict_pc),
    .predict_ready(predict_ready), .predict_taken(predict_taken),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_mispredict(resolve_mispredict),
    .flush(flush), .inflight_count(inflight_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit ptake;
    bit ready;
    bit mis;
    int cnt;
  } exp_t;

  typedef struct {
    int idx;
    bit pred;
  } ment_t;

  exp_t  sbq[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model: counters as plain ints, in-flight branches as a FIFO queue.
  int    pht [PHT_N];
  int    spec_ghr;
  int    arch_ghr;
  ment_t mq[$];

  function automatic void model_reset();
    for (int i = 0; i < PHT_N; i++) pht[i] = CTR_INITV;
    spec_ghr = 0;
    arch_ghr = 0;
    mq.delete();
  endfunction

  function automatic bit head_pred();
    return (mq.size() > 0) ? mq[0].pred : 1'b0;
  endfunction

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // One clock of stimulus, entered and left at posedge+1.
  task automatic cycle(input bit pv, input logic [31:0] pc, input bit rv, input bit rt, input bit fl);
    exp_t  e;
    ment_t m;
    int    idx;
    bit    ptake, acc, racc, mis;
    predict_valid = pv;
    predict_pc    = pc;
    resolve_valid = rv;
    resolve_taken = rt;
    flush         = fl;

    idx   = int'((pc >> PC_LSB) % PHT_N) ^ spec_ghr;
    ptake = (pht[idx] >= TAKEN_MIN);
    acc   = pv && (mq.size() != DEPTH);
    racc  = rv && (mq.size() > 0);
    mis   = racc && (rt != mq[0].pred);
    e.ptake = ptake;
    e.ready = (mq.size() != DEPTH);
    e.mis   = mis;
    e.cnt   = mq.size();
    sbq.push_back(e);

    if (racc) begin
      m = mq.pop_front();
      if (rt) pht[m.idx] = (pht[m.idx] < CTR_MAXV) ? pht[m.idx] + 1 : CTR_MAXV;
      else    pht[m.idx] = (pht[m.idx] > 0) ? pht[m.idx] - 1 : 0;
      arch_ghr = ((arch_ghr * 2) + int'(rt)) % GHR_N;
    end
    if (fl || mis) begin
      mq.delete();
      spec_ghr = arch_ghr;
    end else if (acc) begin
      m.idx  = idx;
      m.pred = ptake;
      mq.push_back(m);
      spec_ghr = ((spec_ghr * 2) + int'(ptake)) % GHR_N;
    end
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset pulse lasting one cycle; outputs are checked while it is held.
  task automatic hit_reset();
    exp_t e;
    predict_valid = 1'b0;
    predict_pc    = '0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    flush         = 1'b0;
    nRST          = 1'b0;
    model_reset();
    e.ptake = 1'b0;
    e.ready = 1'b1;
    e.mis   = 1'b0;
    e.cnt   = 0;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("predict_taken", int'(predict_taken), int'(e.ptake));
      check("predict_ready", int'(predict_ready), int'(e.ready));
      check("resolve_mispredict", int'(resolve_mispredict), int'(e.mis));
      check("inflight_count", int'(inflight_count), e.cnt);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [31:0] pool [4];
    logic [31:0] pc;
    bit          pv, rv, rt, fl;
    pool[0] = 32'h0000_0100;
    pool[1] = 32'h0000_0104;
    pool[2] = 32'h0000_0A08;
    pool[3] = 32'h0000_13FC;

    nRST = 1'b0;
    predict_valid = 1'b0;
    predict_pc    = '0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    flush         = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Training on a single PC, predict and resolve alternating.
    repeat (4) begin
      cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 32'h100, 1'b1, 1'b1, 1'b0);
    end
    cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);

    // Fill the queue; fifth request must be refused; then drain correctly.
    hit_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 32'h0, 1'b1, head_pred(), 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Mispredict on the oldest of three not-taken predictions.
    hit_reset();
    repeat (3) cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);

    // Flush with a same-cycle correct resolve and a discarded accept.
    hit_reset();
    repeat (2) cycle(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h404, 1'b1, head_pred(), 1'b1);
    cycle(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);

    // Simultaneous accept and correct resolve at count 3, then resolve while empty.
    hit_reset();
    repeat (3) cycle(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h504, 1'b1, head_pred(), 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b1, head_pred(), 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Ten accept/resolve pairs with alternating outcomes, crossing the pointer wrap.
    hit_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h600 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h700 + 32'(i * 8), 1'b1, 1'(i % 2), 1'b0);
    end

    // Randomized traffic over a small PC pool so counters actually train.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        hit_reset();
      end else begin
        pv = ($urandom_range(0, 99) < 70);
        pc = pool[$urandom_range(0, 3)];
        if ($urandom_range(0, 3) == 0) pc = $urandom;
        rv = ($urandom_range(0, 99) < 50);
        rt = ($urandom_range(0, 99) < 75) ? head_pred() : 1'($urandom_range(0, 1));
        fl = ($urandom_range(0, 99) < 3);
        cycle(pv, pc, rv, rt, fl);
      end
    end

    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
